// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES cipher datapath: initial AddRoundKey, NUM_ROUNDS-1 full rounds,
// one final round without MixColumns, then a held done handshake.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_SIZE   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start_valid,
  output logic                o_start_ready,
  input  logic                i_abort,
  input  logic                i_stall,
  output logic                o_init_load,
  output logic                o_round_en,
  output logic                o_key_en,
  output logic                o_last_round,
  output logic [CNT_SIZE-1:0] o_round_idx,
  output logic                o_busy,
  output logic                o_done_valid,
  input  logic                i_done_ready
);

  if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
  end

  if ((2 ** CNT_SIZE) <= NUM_ROUNDS) begin : g_bad_cnt_size
    $error("aes_round_ctrl: CNT_SIZE too narrow to hold NUM_ROUNDS");
  end

  localparam logic [CNT_SIZE-1:0] LAST_FULL_IDX = CNT_SIZE'(NUM_ROUNDS - 1);
  localparam logic [CNT_SIZE-1:0] FINAL_IDX     = CNT_SIZE'(NUM_ROUNDS);
  localparam logic [CNT_SIZE-1:0] IDX_ONE       = CNT_SIZE'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_SIZE-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Abort outranks stall, and stall outranks every forward step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (i_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start_valid) begin
            state_d = S_INIT;
            idx_d   = '0;
          end
        end
        S_INIT: begin
          if (!i_stall) begin
            state_d = S_ROUND;
            idx_d   = IDX_ONE;
          end
        end
        S_ROUND: begin
          if (!i_stall) begin
            if (idx_q == LAST_FULL_IDX) begin
              state_d = S_FINAL;
              idx_d   = FINAL_IDX;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end
        end
        S_FINAL: begin
          if (!i_stall) begin
            state_d = S_DONE;
            idx_d   = FINAL_IDX;
          end
        end
        S_DONE: begin
          if (i_done_ready) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Strobes are gated by the stall so each round index fires exactly once.
  always_comb begin
    o_start_ready = 1'b0;
    o_init_load   = 1'b0;
    o_round_en    = 1'b0;
    o_key_en      = 1'b0;
    o_last_round  = 1'b0;
    o_busy        = 1'b0;
    o_done_valid  = 1'b0;
    o_round_idx   = idx_q;
    case (state_q)
      S_IDLE: o_start_ready = 1'b1;
      S_INIT: begin
        o_init_load = !i_stall;
        o_busy      = 1'b1;
      end
      S_ROUND: begin
        o_round_en = !i_stall;
        o_key_en   = !i_stall;
        o_busy     = 1'b1;
      end
      S_FINAL: begin
        o_round_en   = !i_stall;
        o_key_en     = !i_stall;
        o_last_round = 1'b1;
        o_busy       = 1'b1;
      end
      S_DONE: o_done_valid = 1'b1;
      default: o_start_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a 10-round instance and a 14-round instance, each cycle's
// outputs compared as one bundle against a small phase-based model.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a_start = 1'b0, a_abort = 1'b0, a_stall = 1'b0, a_done_ready = 1'b0;
  logic a_start_ready, a_init_load, a_round_en, a_key_en, a_last_round, a_busy, a_done_valid;
  logic [3:0] a_round_idx;

  logic b_start = 1'b0, b_abort = 1'b0, b_stall = 1'b0, b_done_ready = 1'b0;
  logic b_start_ready, b_init_load, b_round_en, b_key_en, b_last_round, b_busy, b_done_valid;
  logic [3:0] b_round_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10), .CNT_SIZE(4)) dut10 (
    .clk(clk), .rst(rst),
    .i_start_valid(a_start), .o_start_ready(a_start_ready),
    .i_abort(a_abort), .i_stall(a_stall),
    .o_init_load(a_init_load), .o_round_en(a_round_en), .o_key_en(a_key_en),
    .o_last_round(a_last_round), .o_round_idx(a_round_idx), .o_busy(a_busy),
    .o_done_valid(a_done_valid), .i_done_ready(a_done_ready)
  );

  aes_round_ctrl #(.NUM_ROUNDS(14), .CNT_SIZE(4)) dut14 (
    .clk(clk), .rst(rst),
    .i_start_valid(b_start), .o_start_ready(b_start_ready),
    .i_abort(b_abort), .i_stall(b_stall),
    .o_init_load(b_init_load), .o_round_en(b_round_en), .o_key_en(b_key_en),
    .o_last_round(b_last_round), .o_round_idx(b_round_idx), .o_busy(b_busy),
    .o_done_valid(b_done_valid), .i_done_ready(b_done_ready)
  );

  wire [10:0] a_vec = {a_start_ready, a_init_load, a_round_en, a_key_en, a_last_round,
                       a_busy, a_done_valid, a_round_idx};
  wire [10:0] b_vec = {b_start_ready, b_init_load, b_round_en, b_key_en, b_last_round,
                       b_busy, b_done_valid, b_round_idx};

  // Phase 0 = IDLE, 1 = INIT, 2..nr = ROUND (idx = phase-1), nr+1 = FINAL, nr+2 = DONE.
  function automatic logic [10:0] exp_vec(input int p, input int nr, input logic st);
    logic sr, il, re, ke, lr, bz, dv;
    logic [3:0] ix;
    sr = 1'b0; il = 1'b0; re = 1'b0; ke = 1'b0; lr = 1'b0; bz = 1'b0; dv = 1'b0; ix = 4'd0;
    if (p == 0) begin
      sr = 1'b1;
    end else if (p == 1) begin
      il = !st; bz = 1'b1;
    end else if (p <= nr) begin
      re = !st; ke = !st; bz = 1'b1; ix = 4'(p - 1);
    end else if (p == nr + 1) begin
      re = !st; ke = !st; lr = 1'b1; bz = 1'b1; ix = 4'(nr);
    end else begin
      dv = 1'b1; ix = 4'(nr);
    end
    return {sr, il, re, ke, lr, bz, dv, ix};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    e = exp_vec(0, 10, 1'b0);
    n_checks++;
    if (a_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL reset_a: got %b expected %b", a_vec, e);
    end
    e = exp_vec(0, 14, 1'b0);
    n_checks++;
    if (b_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL reset_b: got %b expected %b", b_vec, e);
    end
    step();
    e = exp_vec(0, 10, 1'b0);
    n_checks++;
    if (a_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL reset_idle_hold: got %b expected %b", a_vec, e);
    end
  endtask

  task automatic test_nominal(input string tag);
    int kcount;
    int pe;
    logic [10:0] e;
    kcount = 0;
    step();
    a_start = 1'b1; a_done_ready = 1'b1; a_stall = 1'b0; a_abort = 1'b0;
    #1;
    e = exp_vec(0, 10, 1'b0);
    n_checks++;
    if (a_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL %s_accept: got %b expected %b", tag, a_vec, e);
    end
    for (int p = 1; p <= 13; p++) begin
      step();
      a_start = 1'b0;
      #1;
      pe = (p == 13) ? 0 : p;
      e = exp_vec(pe, 10, 1'b0);
      n_checks++;
      if (a_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL %s T+%0d: got %b expected %b", tag, p, a_vec, e);
      end
      if (a_key_en) kcount++;
    end
    n_checks++;
    if (kcount !== 10) begin
      n_fail++;
      $display("[TB] FAIL %s_key_en_count: got %0d expected 10", tag, kcount);
    end
  endtask

  task automatic test_done_hold();
    logic [10:0] e;
    step();
    a_start = 1'b1; a_done_ready = 1'b0;
    #1;
    for (int p = 1; p <= 12; p++) begin
      step();
      a_start = 1'b0;
      #1;
      e = exp_vec(p, 10, 1'b0);
      n_checks++;
      if (a_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL hold_run T+%0d: got %b expected %b", p, a_vec, e);
      end
    end
    for (int h = 0; h < 5; h++) begin
      step();
      a_start = 1'b1;
      #1;
      e = exp_vec(12, 10, 1'b0);
      n_checks++;
      if (a_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL hold_done cycle %0d: got %b expected %b", h, a_vec, e);
      end
    end
    step();
    a_start = 1'b0; a_done_ready = 1'b1;
    #1;
    e = exp_vec(12, 10, 1'b0);
    n_checks++;
    if (a_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL hold_release: got %b expected %b", a_vec, e);
    end
    step();
    e = exp_vec(0, 10, 1'b0);
    n_checks++;
    if (a_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL hold_to_idle: got %b expected %b", a_vec, e);
    end
  endtask

  task automatic test_stall();
    int p, c, stall_left, n4, done_at, pe;
    logic [10:0] e;
    p = 1; c = 0; stall_left = 3; n4 = 0; done_at = -1;
    step();
    a_start = 1'b1; a_done_ready = 1'b1;
    #1;
    while (p <= 13 && c < 40) begin
      step();
      c++;
      a_start = 1'b0;
      a_stall = (p == 5 && stall_left > 0);
      #1;
      pe = (p == 13) ? 0 : p;
      e = exp_vec(pe, 10, a_stall);
      n_checks++;
      if (a_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL stall T+%0d: got %b expected %b", c, a_vec, e);
      end
      if (a_round_en && a_round_idx == 4'd4) n4++;
      if (a_done_valid && done_at < 0) done_at = c;
      if (a_stall) stall_left--;
      else p++;
    end
    a_stall = 1'b0;
    n_checks++;
    if (n4 !== 1) begin
      n_fail++;
      $display("[TB] FAIL stall_idx4_pulses: got %0d expected 1", n4);
    end
    n_checks++;
    if (done_at !== 15) begin
      n_fail++;
      $display("[TB] FAIL stall_done_latency: got T+%0d expected T+15", done_at);
    end
  endtask

  task automatic test_abort();
    logic [10:0] e;
    step();
    a_start = 1'b1; a_done_ready = 1'b1;
    #1;
    for (int p = 1; p <= 7; p++) begin
      step();
      a_start = 1'b0;
      a_abort = (p == 7);
      #1;
      e = exp_vec(p, 10, 1'b0);
      n_checks++;
      if (a_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL abort_run T+%0d: got %b expected %b", p, a_vec, e);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      a_abort = 1'b0;
      #1;
      e = exp_vec(0, 10, 1'b0);
      n_checks++;
      if (a_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL abort_idle cycle %0d: got %b expected %b", k, a_vec, e);
      end
    end
    test_nominal("post_abort");
  endtask

  task automatic test_reset_in_final();
    logic [10:0] e;
    step();
    a_start = 1'b1; a_done_ready = 1'b1;
    #1;
    for (int p = 1; p <= 11; p++) begin
      step();
      a_start = 1'b0;
      rst = (p == 11);
      #1;
      e = exp_vec(p, 10, 1'b0);
      n_checks++;
      if (a_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL rstfinal_run T+%0d: got %b expected %b", p, a_vec, e);
      end
    end
    step();
    rst = 1'b0;
    #1;
    e = exp_vec(0, 10, 1'b0);
    n_checks++;
    if (a_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL rstfinal_idle: got %b expected %b", a_vec, e);
    end
  endtask

  task automatic test_rounds14();
    int pe;
    logic [10:0] e;
    step();
    b_start = 1'b1; b_abort = 1'b1; b_done_ready = 1'b1;
    #1;
    e = exp_vec(0, 14, 1'b0);
    n_checks++;
    if (b_vec !== e) begin
      n_fail++;
      $display("[TB] FAIL r14_accept: got %b expected %b", b_vec, e);
    end
    for (int p = 1; p <= 17; p++) begin
      step();
      b_start = 1'b0; b_abort = 1'b0;
      #1;
      pe = (p == 17) ? 0 : p;
      e = exp_vec(pe, 14, 1'b0);
      n_checks++;
      if (b_vec !== e) begin
        n_fail++;
        $display("[TB] FAIL r14 T+%0d: got %b expected %b", p, b_vec, e);
      end
    end
  endtask

  initial begin
    $display("[TB] aes_round_ctrl bench start");
    test_reset();
    test_nominal("nominal");
    test_done_hold();
    test_stall();
    test_abort();
    test_reset_in_final();
    test_rounds14();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
